// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT datapath blocks.
package fft_pkg;

  localparam int FFT_N = 3;
  localparam int FFT_W = 16;

  // Complex fixed-point sample; re occupies the upper half when packed.
  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cpx_fix_t;

  typedef enum logic {
    WR_IDLE,
    WR_FILL
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RUN
  } rd_state_t;

  // Reverse the low n bits of idx. Upper bits of the result are zero.
  function automatic logic [FFT_N-1:0] bitrev(input logic [FFT_N-1:0] idx,
                                              input int unsigned n);
    logic [FFT_N-1:0] rev;
    for (int i = 0; i < FFT_N; i++) begin
      rev[i] = idx[FFT_N-1-i];
    end
    return rev >> (FFT_N - n);
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// Ping-pong sample store: simple dual-port RAM holding two frames.
// Address is {bank, offset}; read data is registered (1 clk latency).
import fft_pkg::*;

module fft_reorder_bank #(
  parameter int N = FFT_N,
  parameter int W = FFT_W
) (
  input  logic           clk,
  input  logic           we,
  input  logic [N:0]     wr_addr,
  input  logic [2*W-1:0] wr_data,
  input  logic [N:0]     rd_addr,
  output logic [2*W-1:0] rd_data
);

  logic [2*W-1:0] mem [2**(N+1)];

  // One write port and one registered read port; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_reorder.sv
// Converts bit-reversed FFT output frames into natural order using a
// ping-pong buffer, so consecutive frames stream without gaps.
import fft_pkg::*;

module fft_reorder #(
  parameter int N = FFT_N,
  parameter int W = FFT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] ip_re,
  input  logic signed [W-1:0] ip_im,
  input  logic                start_ip,
  output logic signed [W-1:0] op_re,
  output logic signed [W-1:0] op_im,
  output logic [N-1:0]        op_idx,
  output logic                op_valid,
  output logic                start_op
);

  localparam logic [N-1:0] LAST = '1;

  wr_state_t      wr_state, wr_state_next;
  logic [N-1:0]   wr_cnt, wr_cnt_next;
  logic           wr_bank, wr_bank_next;
  logic           wr_en;
  logic [N-1:0]   wr_idx;
  logic           frame_done;

  rd_state_t      rd_state, rd_state_next;
  logic [N-1:0]   rd_cnt, rd_cnt_next;
  logic           rd_bank, rd_bank_next;
  logic           rd_armed;

  logic           rd_vld_q;
  logic [N-1:0]   rd_idx_q;
  logic [2*W-1:0] rd_data;
  cpx_fix_t       rd_cpx;

  // Write side: a start always restarts at sample 0 in the current bank, which
  // discards any partial frame; the bank only flips once a frame is complete.
  always_comb begin
    wr_state_next = wr_state;
    wr_cnt_next   = wr_cnt;
    wr_bank_next  = wr_bank;
    wr_en         = 1'b0;
    wr_idx        = wr_cnt;
    frame_done    = 1'b0;
    if (start_ip) begin
      wr_en         = 1'b1;
      wr_idx        = '0;
      wr_cnt_next   = N'(1);
      wr_state_next = WR_FILL;
    end else if (wr_state == WR_FILL) begin
      wr_en       = 1'b1;
      wr_cnt_next = wr_cnt + 1'b1;
      if (wr_cnt == LAST) begin
        frame_done    = 1'b1;
        wr_bank_next  = ~wr_bank;
        wr_state_next = WR_IDLE;
      end
    end
  end

  // Write-side state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
    end else begin
      wr_state <= wr_state_next;
      wr_cnt   <= wr_cnt_next;
      wr_bank  <= wr_bank_next;
    end
  end

  // A completed frame arms the read of the bank just filled. Frames complete at
  // most once every L cycles, so arming never lands mid-read: it either starts
  // from idle or coincides with the last read of the previous frame.
  assign rd_armed = frame_done;

  // Read side: walk offsets 0..L-1 of the armed bank in natural order.
  always_comb begin
    rd_state_next = rd_state;
    rd_cnt_next   = rd_cnt;
    rd_bank_next  = rd_bank;
    if (rd_armed) begin
      rd_state_next = RD_RUN;
      rd_cnt_next   = '0;
      rd_bank_next  = wr_bank;
    end else if (rd_state == RD_RUN) begin
      rd_cnt_next = rd_cnt + 1'b1;
      if (rd_cnt == LAST) begin
        rd_state_next = RD_IDLE;
      end
    end
  end

  // Read-side state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
    end else begin
      rd_state <= rd_state_next;
      rd_cnt   <= rd_cnt_next;
      rd_bank  <= rd_bank_next;
    end
  end

  fft_reorder_bank #(
    .N(N),
    .W(W)
  ) u_bank (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr ({wr_bank, bitrev(wr_idx, N)}),
    .wr_data ({ip_re, ip_im}),
    .rd_addr ({rd_bank, rd_cnt}),
    .rd_data (rd_data)
  );

  assign rd_cpx = rd_data;

  // Delay valid and index alongside the RAM's registered read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      rd_vld_q <= (rd_state == RD_RUN);
      rd_idx_q <= rd_cnt;
    end
  end

  // Output register; sample and index hold their last value between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_re    <= '0;
      op_im    <= '0;
      op_idx   <= '0;
      op_valid <= 1'b0;
      start_op <= 1'b0;
    end else begin
      op_valid <= rd_vld_q;
      start_op <= rd_vld_q && (rd_idx_q == '0);
      if (rd_vld_q) begin
        op_re  <= rd_cpx.re;
        op_im  <= rd_cpx.im;
        op_idx <= rd_idx_q;
      end
    end
  end

endmodule
